// File: rtl/sms_oc_bus_sequencer.sv
// Round-robin arbiter and sequencer for a shared wired-AND open-collector bus.
// Each transfer drives the granted word, lets the bus settle, samples it and then releases it.
module sms_oc_bus_sequencer #(
    parameter int N_REQ  = 4,
    parameter int W      = 6,
    parameter int SETTLE = 3,
    parameter int GUARD  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       tx_data,
    input  logic [W-1:0]             bus_in,
    input  logic                     clr_fault,
    output logic [N_REQ-1:0]         gnt,
    output logic [W-1:0]             oc_pull,
    output logic [W-1:0]             rx_data,
    output logic                     rx_valid,
    output logic [$clog2(N_REQ)-1:0] rx_src,
    output logic                     fault,
    output logic [1:0]               fault_code
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (SETTLE > GUARD) ? SETTLE : GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_GUARD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] cur, cur_nxt, last, last_nxt;
    logic [W-1:0]     word, word_nxt, pull_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic             prev_idle, err_mis, err_flt;

    // First requester strictly after prev in circular order; prev itself has lowest priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] prev);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = prev;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(prev) + k) % N_REQ;
            if (!found && r[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cur       <= '0;
            last      <= LAST_RST;
            prev_idle <= 1'b0;
            gnt       <= '0;
            oc_pull   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur       <= cur_nxt;
            last      <= last_nxt;
            prev_idle <= (state == S_IDLE);
            gnt       <= gnt_nxt;
            oc_pull   <= pull_nxt;
        end
    end

    always_ff @(posedge clk) begin
        word <= word_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur;
        last_nxt  = last;
        word_nxt  = word;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    cur_nxt   = rr_pick(req, last);
                    word_nxt  = tx_data[cur_nxt*W +: W];
                    last_nxt  = cur_nxt;
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt == '0) state_nxt = S_SAMPLE;
                else           cnt_nxt   = cnt - CNT_ONE;
            end
            S_SAMPLE: begin
                cnt_nxt   = GUARD_LD;
                state_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (cnt == '0) state_nxt = S_IDLE;
                else           cnt_nxt   = cnt - CNT_ONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so gnt/oc_pull come straight out of flops.
    always_comb begin
        gnt_nxt  = '0;
        pull_nxt = '0;
        if (state_nxt == S_DRIVE || state_nxt == S_SAMPLE) begin
            gnt_nxt[cur_nxt] = 1'b1;
            pull_nxt         = ~word_nxt;
        end
    end

    assign err_mis = (state == S_SAMPLE) && (bus_in != word);
    assign err_flt = (state == S_IDLE) && prev_idle && (bus_in != '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid   <= 1'b0;
            rx_data    <= '1;
            rx_src     <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            rx_valid <= (state == S_SAMPLE);
            if (state == S_SAMPLE) begin
                rx_data <= bus_in;
                rx_src  <= cur;
            end
            // A new error overrides a simultaneous clear; otherwise the first error sticks.
            if (err_mis || err_flt) begin
                if (!fault || clr_fault) begin
                    fault      <= 1'b1;
                    fault_code <= err_mis ? 2'b01 : 2'b10;
                end
            end else if (clr_fault) begin
                fault      <= 1'b0;
                fault_code <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_sms_oc_bus_sequencer.sv
// Directed bench for sms_oc_bus_sequencer; the bus is modelled as ~oc_pull with a force-low mask.
module tb_sms_oc_bus_sequencer;
    localparam int N_REQ = 4;
    localparam int W     = 6;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] tx_data;
    logic [W-1:0]       bus_in;
    logic [W-1:0]       force_low;
    logic               clr_fault;
    logic [N_REQ-1:0]   gnt;
    logic [W-1:0]       oc_pull;
    logic [W-1:0]       rx_data;
    logic               rx_valid;
    logic [1:0]         rx_src;
    logic               fault;
    logic [1:0]         fault_code;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [W-1:0] words [N_REQ];

    assign bus_in = ~oc_pull & ~force_low;

    sms_oc_bus_sequencer #(.N_REQ(N_REQ), .W(W), .SETTLE(3), .GUARD(1)) dut (
        .clk(clk), .rst(rst), .req(req), .tx_data(tx_data), .bus_in(bus_in),
        .clr_fault(clr_fault), .gnt(gnt), .oc_pull(oc_pull), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_src(rx_src), .fault(fault), .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [W-1:0]     exp_pull;
        logic [N_REQ-1:0] exp_gnt;
        int               idx;
        int               pulses;

        rst       = 1'b0;
        req       = '0;
        clr_fault = 1'b0;
        force_low = '0;
        words[0]  = 6'b101010;
        words[1]  = 6'b111111;
        words[2]  = 6'b110011;
        words[3]  = 6'b001100;
        tx_data   = '1;
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_pull", 32'(oc_pull), 32'h0);
        check("rst_rxv", 32'(rx_valid), 32'h0);
        check("rst_rxdata", 32'(rx_data), 32'h3F);
        check("rst_rxsrc", 32'(rx_src), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_code", 32'(fault_code), 32'h0);
        rst = 1'b0;

        // Single request from requester 0
        tx_data[0 +: W] = words[0];
        req = 4'b0001;
        tick();
        req = '0;
        check("single_gnt0", 32'(gnt), 32'h1);
        check("single_pull", 32'(oc_pull), 32'h15);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("single_gnt_hold", 32'(gnt), 32'h1);
            check("single_rxv_early", 32'(rx_valid), 32'h0);
        end
        tick();
        check("single_gnt_rel", 32'(gnt), 32'h0);
        check("single_pull_rel", 32'(oc_pull), 32'h0);
        check("single_rxv", 32'(rx_valid), 32'h1);
        check("single_rxdata", 32'(rx_data), 32'h2A);
        check("single_rxsrc", 32'(rx_src), 32'h0);
        check("single_fault", 32'(fault), 32'h0);
        tick();
        check("single_rxv_pulse", 32'(rx_valid), 32'h0);

        // Round-robin with all requesters held high, starting from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) tx_data[i*W +: W] = words[i];
        req = '1;
        for (int k = 0; k < 5; k++) begin
            idx = k % N_REQ;
            exp_gnt = '0;
            exp_gnt[idx] = 1'b1;
            exp_pull = ~words[idx];
            tick();
            check("rr_gnt", 32'(gnt), 32'(exp_gnt));
            check("rr_pull", 32'(oc_pull), 32'(exp_pull));
            for (int j = 1; j < 4; j++) begin
                tick();
                check("rr_gnt_hold", 32'(gnt), 32'(exp_gnt));
            end
            tick();
            check("rr_gnt_guard", 32'(gnt), 32'h0);
            check("rr_rxv", 32'(rx_valid), 32'h1);
            check("rr_rxsrc", 32'(rx_src), 32'(idx));
            check("rr_rxdata", 32'(rx_data), 32'(words[idx]));
            tick();
            check("rr_gnt_idle", 32'(gnt), 32'h0);
            check("rr_pull_idle", 32'(oc_pull), 32'h0);
        end
        req = '0;
        tick();
        check("rr_fault", 32'(fault), 32'h0);

        // Contention: bit 2 pulled low by someone else while requester 1 releases all lines
        req = 4'b0010;
        tick();
        req = '0;
        check("cont_gnt", 32'(gnt), 32'h2);
        force_low = 6'b000100;
        tick();
        tick();
        tick();
        tick();
        check("cont_fault", 32'(fault), 32'h1);
        check("cont_code", 32'(fault_code), 32'h1);
        check("cont_rxdata", 32'(rx_data), 32'h3B);
        check("cont_rxsrc", 32'(rx_src), 32'h1);
        force_low = '0;
        tick();
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("cont_clr_fault", 32'(fault), 32'h0);
        check("cont_clr_code", 32'(fault_code), 32'h0);

        // Stuck line in IDLE, then clear-vs-error and a later mismatch
        force_low = 6'b000001;
        tick();
        check("stuck_fault", 32'(fault), 32'h1);
        check("stuck_code", 32'(fault_code), 32'h2);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("stuck_err_wins", 32'(fault), 32'h1);
        check("stuck_err_wins_code", 32'(fault_code), 32'h2);
        req = 4'b0100;
        tick();
        req = '0;
        check("stuck_gnt", 32'(gnt), 32'h4);
        tick();
        tick();
        tick();
        tick();
        check("stuck_rxdata", 32'(rx_data), 32'h32);
        check("stuck_code_sticky", 32'(fault_code), 32'h2);
        force_low = '0;
        tick();
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("stuck_clr", 32'(fault), 32'h0);

        // Asynchronous reset in the middle of DRIVE
        req = 4'b0001;
        tick();
        req = '0;
        check("rstmid_gnt", 32'(gnt), 32'h1);
        tick();
        tick();
        check("rstmid_gnt_hold", 32'(gnt), 32'h1);
        rst = 1'b1;
        #1;
        check("rstmid_gnt_async", 32'(gnt), 32'h0);
        check("rstmid_pull_async", 32'(oc_pull), 32'h0);
        check("rstmid_rxdata", 32'(rx_data), 32'h3F);
        tick();
        rst = 1'b0;
        req = 4'b1000;
        tick();
        req = '0;
        check("rstmid_gnt3", 32'(gnt), 32'h8);
        check("rstmid_pull3", 32'(oc_pull), 32'h33);
        tick();
        tick();
        tick();
        tick();
        check("rstmid_rxv", 32'(rx_valid), 32'h1);
        check("rstmid_rxsrc", 32'(rx_src), 32'h3);
        check("rstmid_rxdata3", 32'(rx_data), 32'h0C);
        tick();

        // Late change of data and request after the word was latched
        req = 4'b0100;
        tick();
        check("late_gnt", 32'(gnt), 32'h4);
        req = '0;
        tx_data[2*W +: W] = 6'b000000;
        tick();
        check("late_pull", 32'(oc_pull), 32'h0C);
        tick();
        tick();
        tick();
        check("late_rxv", 32'(rx_valid), 32'h1);
        check("late_rxdata", 32'(rx_data), 32'h33);
        check("late_rxsrc", 32'(rx_src), 32'h2);
        check("late_fault", 32'(fault), 32'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rx_valid) pulses++;
        end
        check("late_single_pulse", 32'(pulses), 32'h0);
        check("late_gnt_idle", 32'(gnt), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sms_oc_bus_sequencer.md
# sms_oc_bus_sequencer

Sequencer and round-robin arbiter for a shared open-collector (wired-AND, pulled-up) line bus built from SDTRL inverter cards whose outputs float when off. It grants the bus to one of N requesters and drives the granted word as open-collector pull-downs. It then waits a settle time, samples the resolved bus and releases it through a guard interval. Contention and stuck lines are flagged. It sits between the card-level models and the digit-transfer control logic.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 6, bus width in bits (C,F,8,4,2,1 digit)
- SETTLE, 3, drive cycles before sample (>=1)
- GUARD, 1, released cycles after sample (>=1)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  request lines, level
- tx_data  in  N_REQ*W  requester i word at [i*W +: W]; 1 = line released/high
- bus_in  in  W  resolved bus level; a floating line reads 1
- clr_fault  in  1  synchronous clear of fault
- gnt  out  N_REQ  one-hot grant
- oc_pull  out  W  1 = pull line low; 0 = transistor off (line floats high)
- rx_data  out  W  word sampled from bus
- rx_valid  out  1  one-cycle pulse, rx_data/rx_src valid
- rx_src  out  clog2(N_REQ)  requester index of the last transfer
- fault  out  1  sticky error flag
- fault_code  out  2  01 = sample mismatch, 10 = bus not floating in IDLE

## Operation
- States: IDLE, DRIVE, SAMPLE, GUARD.
- IDLE: oc_pull=0 and gnt=0. If any req is high, pick the first requester after `last` in round-robin order. Latch its tx_data into `word` and its index into `cur`, set last=cur, and go to DRIVE.
- Reset value of `last` is N_REQ-1, so requester 0 wins first.
- DRIVE: gnt[cur]=1 and oc_pull=~word. Held for SETTLE cycles, counted by a down-counter, then go to SAMPLE.
- SAMPLE (1 cycle): gnt and oc_pull are unchanged. Register rx_data<=bus_in, rx_src<=cur, and pulse rx_valid on the following cycle. If bus_in!=word, set fault with code 01. Then go to GUARD.
- GUARD: gnt=0 and oc_pull=0 for GUARD cycles, then go to IDLE.
- req is only examined in IDLE. Dropping req after grant does not abort the transfer. tx_data changes after latching are ignored.
- IDLE float check: on any IDLE cycle where the previous state was also IDLE and bus_in is not all-ones, set fault with code 10. The first IDLE cycle after GUARD is exempt.
- fault is sticky. fault_code holds the first error until cleared.
- clr_fault clears fault and fault_code. If an error condition occurs in the same cycle as clr_fault, the error wins.
- Reset mid-transfer immediately forces IDLE, gnt=0, oc_pull=0, rx_valid=0, fault=0, fault_code=0, rx_data=all-ones, rx_src=0, last=N_REQ-1.
- Requests arriving while busy wait. No requester is starved: the worst-case wait is N_REQ-1 transfers.

## Timing
- Req seen high in IDLE at edge t: gnt and oc_pull are valid after edge t+1.
- DRIVE occupies cycles t+1..t+SETTLE. SAMPLE is cycle t+SETTLE+1.
- rx_valid is high in cycle t+SETTLE+2, which is the first GUARD cycle.
- Back in IDLE at t+SETTLE+GUARD+2. One transfer costs SETTLE+GUARD+2 cycles (6 at defaults).
- gnt and oc_pull are registered and glitch-free. oc_pull is never nonzero while gnt is zero.
- At least GUARD+1 released cycles separate the pull-downs of consecutive owners.

## Test plan
- Single request: req=0001 with tx_data[0]=6'b101010 and bus_in modelled as ~oc_pull. Required: gnt=0001 for 4 cycles, oc_pull=010101, rx_valid 5 cycles after req is sampled, rx_data=101010, rx_src=0, fault=0.
- Round-robin: req=1111 held continuously. Required: grant order 0,1,2,3,0 with a transfer every 6 cycles, and gnt never high in GUARD or IDLE.
- Contention: the bench forces bus_in[2]=0 while requester 1 drives 6'b111111. Required: fault=1, fault_code=01, rx_data=111011. Then pulse clr_fault: fault=0.
- Stuck line in IDLE: bus_in=111110 for 2 idle cycles with no requests. Required: fault=1 with code 10. A second error does not change fault_code.
- Reset mid-DRIVE: assert rst two cycles after grant. Required: gnt=0 and oc_pull=0 without waiting for a clock edge. After release, req=1000 is granted to requester 3 on the next cycle.
- Late change: tx_data[2] changes and req[2] drops during DRIVE. Required: the transfer completes with the originally latched word and rx_valid pulses once.
